// File: rtl/pipe_mul_div_pkg.sv
// pipe_mul_div_pkg: RV32M funct3 encodings and FSM state encodings shared by the mul/div unit
package pipe_mul_div_pkg;
  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;
  typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIXUP, ST_DONE} state_t;
endpackage

// File: rtl/pipe_div_step.sv
// pipe_div_step: UNROLL combinational restoring-divide steps on unsigned operands
module pipe_div_step
  import pipe_mul_div_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);
  logic [XLEN:0] part;
  logic          ge;
  // shift the next dividend bit into the XLEN+1 partial remainder, subtract the divisor when it fits
  always_comb begin
    rem_next = rem;
    quo_next = quo;
    part     = '0;
    ge       = 1'b0;
    for (int i = 0; i < UNROLL; i++) begin
      part     = {rem_next, quo_next[XLEN-1]};
      ge       = part >= {1'b0, dvsr};
      rem_next = XLEN'(ge ? part - {1'b0, dvsr} : part);
      quo_next = {quo_next[XLEN-2:0], ge};
    end
  end
endmodule

// File: rtl/pipe_mul_div_unit.sv
// pipe_mul_div_unit: multi-cycle RV32M unit (shift-add multiply, restoring divide); PIPE_MUL_DIV_FAST_MUL_EN selects a single-cycle multiplier
module pipe_mul_div_unit
  import pipe_mul_div_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1Data,
  input  logic [XLEN-1:0] rs2Data,
  input  logic            stepPipe,
  input  logic            flush,
  output logic            busy,
  output logic            currentPipeStall,
  output logic            resultValid,
  output logic [XLEN-1:0] result
);
  localparam int K  = XLEN / UNROLL;
  localparam int CW = $clog2(K + 1);
  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic              sa, sb;
  logic [XLEN-1:0]   mcand, dvsr, rem, rem_nxt, quo_nxt, fix;
  logic [2*XLEN-1:0] acc, mul_nxt, prod;
  logic              signed_a, signed_b, in_sa, in_sb, div0, ovf, special, direct;
  logic [XLEN-1:0]   abs_a, abs_b, special_res, direct_res;
  assign signed_a    = !(funct3 == FUNCT3_MULHU || funct3 == FUNCT3_DIVU || funct3 == FUNCT3_REMU);
  assign signed_b    = signed_a && funct3 != FUNCT3_MULHSU;
  assign in_sa       = signed_a & rs1Data[XLEN-1];
  assign in_sb       = signed_b & rs2Data[XLEN-1];
  assign abs_a       = in_sa ? -rs1Data : rs1Data;
  assign abs_b       = in_sb ? -rs2Data : rs2Data;
  assign div0        = funct3[2] && rs2Data == '0;
  assign ovf         = funct3[2] && !funct3[0] && rs1Data == {1'b1, {(XLEN-1){1'b0}}} && rs2Data == '1;
  assign special     = div0 || ovf;
  assign special_res = div0 ? (funct3[1] ? rs1Data : '1) : (funct3[1] ? '0 : rs1Data);
`ifdef PIPE_MUL_DIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_p;
  assign fast_p      = {{XLEN{in_sa}}, rs1Data} * {{XLEN{in_sb}}, rs2Data};
  assign direct      = special || !funct3[2];
  assign direct_res  = special ? special_res : (funct3 == FUNCT3_MUL ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN]);
`else
  assign direct      = special;
  assign direct_res  = special_res;
`endif
  assign busy             = state != ST_IDLE;
  assign resultValid      = state == ST_DONE;
  assign currentPipeStall = start && !resultValid;
  assign prod = (sa ^ sb) ? -acc : acc;
  assign fix  = !op[2] ? (op == FUNCT3_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
              : op[1]  ? (sa ? -rem : rem)
              : ((sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
  pipe_div_step #(.XLEN(XLEN), .UNROLL(UNROLL)) u_div_step (
    .rem      (rem),
    .quo      (acc[XLEN-1:0]),
    .dvsr     (dvsr),
    .rem_next (rem_nxt),
    .quo_next (quo_nxt)
  );
  // UNROLL shift-add steps: add the multiplicand on a set multiplier bit, then shift the accumulator right
  always_comb begin
    mul_nxt = acc;
    for (int i = 0; i < UNROLL; i++)
      mul_nxt = {{1'b0, mul_nxt[2*XLEN-1:XLEN]} + ({1'b0, mcand} & {(XLEN+1){mul_nxt[0]}}), mul_nxt[XLEN-1:1]};
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end
  // next state; flush wins over everything, start is only honoured in IDLE
  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = ST_IDLE;
    else case (state)
      ST_IDLE:        state_nxt = !start ? ST_IDLE : direct ? ST_DONE : funct3[2] ? ST_DIV : ST_MUL;
      ST_MUL, ST_DIV: state_nxt = cnt == '0 ? ST_FIXUP : state;
      ST_FIXUP:       state_nxt = ST_DONE;
      ST_DONE:        state_nxt = stepPipe ? ST_IDLE : ST_DONE;
      default:        state_nxt = ST_IDLE;
    endcase
  end
  // operand capture, iteration and result registers; a flush leaves them untouched
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= '0;
      result <= '0;
      acc    <= '0;
      rem    <= '0;
      mcand  <= '0;
      dvsr   <= '0;
      op     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
    end else if (!flush) begin
      case (state)
        ST_IDLE: if (start) begin
          op    <= funct3;
          sa    <= in_sa;
          sb    <= in_sb;
          mcand <= abs_a;
          dvsr  <= abs_b;
          rem   <= '0;
          acc   <= {{XLEN{1'b0}}, funct3[2] ? abs_a : abs_b};
          cnt   <= CW'(K - 1);
          if (direct) result <= direct_res;
        end
        ST_MUL: begin
          acc <= mul_nxt;
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        ST_DIV: begin
          acc[XLEN-1:0] <= quo_nxt;
          rem           <= rem_nxt;
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        ST_FIXUP: result <= fix;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_mul_div_unit.sv
// tb_pipe_mul_div_unit: directed self-checking bench for pipe_mul_div_unit (UNROLL=1 and UNROLL=4 instances)
module tb_pipe_mul_div_unit;
  import pipe_mul_div_pkg::*;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, stepPipe = 1'b0, flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1Data = '0, rs2Data = '0;
  logic        busy, currentPipeStall, resultValid, busy4, stall4, rv4;
  logic [31:0] result, result4;
  int total = 0, bad = 0;
`ifdef PIPE_MUL_DIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam logic [2:0]  MUL_F [4] = '{FUNCT3_MUL, FUNCT3_MULH, FUNCT3_MULHU, FUNCT3_MULHSU};
  localparam logic [31:0] MUL_A [4] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
  localparam logic [31:0] MUL_B [4] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd2};
  localparam logic [31:0] MUL_E [4] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
  localparam logic [2:0]  DIV_F [4] = '{FUNCT3_DIV, FUNCT3_REM, FUNCT3_DIVU, FUNCT3_REMU};
  localparam logic [31:0] DIV_A [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
  localparam logic [31:0] DIV_B [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
  localparam logic [31:0] DIV_E [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
  localparam logic [2:0]  SP_F [4]  = '{FUNCT3_DIV, FUNCT3_REM, FUNCT3_DIV, FUNCT3_REM};
  localparam logic [31:0] SP_A [4]  = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
  localparam logic [31:0] SP_B [4]  = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  localparam logic [31:0] SP_E [4]  = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};

  pipe_mul_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .rs1Data(rs1Data), .rs2Data(rs2Data),
    .stepPipe(stepPipe), .flush(flush), .busy(busy), .currentPipeStall(currentPipeStall),
    .resultValid(resultValid), .result(result)
  );
  pipe_mul_div_unit #(.UNROLL(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .rs1Data(rs1Data), .rs2Data(rs2Data),
    .stepPipe(stepPipe), .flush(flush), .busy(busy4), .currentPipeStall(stall4),
    .resultValid(rv4), .result(result4)
  );

  always #5 clk = ~clk;

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    funct3 = f3; rs1Data = a; rs2Data = b; start = 1'b1; lat = 0;
    while (!resultValid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    res = result;
    stepPipe = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    stepPipe = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; funct3 = FUNCT3_DIV; rs1Data = 32'd9; rs2Data = 32'd2;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (resultValid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", resultValid); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 00000000", result); end
    total++; if (currentPipeStall !== 1'b1) begin bad++; $display("FAIL reset_stall: got %b want 1", currentPipeStall); end
    total++; if (busy4 !== 1'b0 || result4 !== 32'h0) begin bad++; $display("FAIL reset_u4: got busy=%b res=%h want 0/0", busy4, result4); end
    start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [31:0] r;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(MUL_F[i], MUL_A[i], MUL_B[i], r, lat);
      total++; if (r !== MUL_E[i]) begin bad++; $display("FAIL mul_%0d_result: got %h want %h", i, r, MUL_E[i]); end
      total++; if (lat !== MUL_LAT) begin bad++; $display("FAIL mul_%0d_latency: got %0d want %0d", i, lat, MUL_LAT); end
    end
  endtask

  task automatic test_div();
    logic [31:0] r;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(DIV_F[i], DIV_A[i], DIV_B[i], r, lat);
      total++; if (r !== DIV_E[i]) begin bad++; $display("FAIL div_%0d_result: got %h want %h", i, r, DIV_E[i]); end
      total++; if (lat !== 34) begin bad++; $display("FAIL div_%0d_latency: got %0d want 34", i, lat); end
    end
  endtask

  task automatic test_special();
    logic [31:0] r;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(SP_F[i], SP_A[i], SP_B[i], r, lat);
      total++; if (r !== SP_E[i]) begin bad++; $display("FAIL special_%0d_result: got %h want %h", i, r, SP_E[i]); end
      total++; if (lat !== 1) begin bad++; $display("FAIL special_%0d_latency: got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_abort(input bit use_rst);
    logic [31:0] prev, r;
    int lat;
    prev = result;
    funct3 = FUNCT3_DIV; rs1Data = 32'd1000; rs2Data = 32'd7; start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      total++; if (resultValid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL abort%0d_run_c%0d: got valid=%b busy=%b want 0/1", use_rst, i, resultValid, busy); end
    end
    if (use_rst) rst = 1'b0; else flush = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || resultValid !== 1'b0) begin bad++; $display("FAIL abort%0d_idle: got busy=%b valid=%b want 0/0", use_rst, busy, resultValid); end
    total++; if (result !== (use_rst ? 32'h0 : prev)) begin bad++; $display("FAIL abort%0d_result: got %h want %h", use_rst, result, use_rst ? 32'h0 : prev); end
    total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL abort%0d_u4_idle: got %b want 0", use_rst, busy4); end
    start = 1'b0; flush = 1'b0; rst = 1'b1;
    do_op(FUNCT3_DIVU, 32'd9, 32'd3, r, lat);
    total++; if (r !== 32'd3) begin bad++; $display("FAIL abort%0d_next_result: got %h want 00000003", use_rst, r); end
    total++; if (lat !== 34) begin bad++; $display("FAIL abort%0d_next_latency: got %0d want 34", use_rst, lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int n, lat;
    funct3 = FUNCT3_MUL; rs1Data = 32'd7; rs2Data = 32'hFFFFFFFD; start = 1'b1; n = 0;
    while (!resultValid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (resultValid !== 1'b1 || result !== 32'hFFFFFFEB) begin bad++; $display("FAIL hold_c%0d: got valid=%b res=%h want 1/ffffffeb", i, resultValid, result); end
      total++; if (busy !== 1'b1 || currentPipeStall !== 1'b0) begin bad++; $display("FAIL hold_stall_c%0d: got busy=%b stall=%b want 1/0", i, busy, currentPipeStall); end
    end
    stepPipe = 1'b1; funct3 = FUNCT3_DIVU; rs1Data = 32'd100; rs2Data = 32'd7;
    @(posedge clk); #1;
    stepPipe = 1'b0;
    total++; if (busy !== 1'b0 || resultValid !== 1'b0) begin bad++; $display("FAIL b2b_idle: got busy=%b valid=%b want 0/0", busy, resultValid); end
    total++; if (currentPipeStall !== 1'b1) begin bad++; $display("FAIL b2b_stall: got %b want 1", currentPipeStall); end
    do_op(FUNCT3_DIVU, 32'd100, 32'd7, r, lat);
    total++; if (r !== 32'd14) begin bad++; $display("FAIL b2b_result: got %h want 0000000e", r); end
    total++; if (lat !== 34) begin bad++; $display("FAIL b2b_latency: got %0d want 34", lat); end
  endtask

  task automatic test_unroll4();
    int n, lat4;
    logic [31:0] r4;
    funct3 = FUNCT3_DIVU; rs1Data = 32'd100; rs2Data = 32'd7; start = 1'b1; n = 0;
    while (!rv4 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    lat4 = n; r4 = result4;
    while (!resultValid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    total++; if (lat4 !== 10) begin bad++; $display("FAIL u4_latency: got %0d want 10", lat4); end
    total++; if (r4 !== 32'd14) begin bad++; $display("FAIL u4_result: got %h want 0000000e", r4); end
    total++; if (result !== 32'd14) begin bad++; $display("FAIL u4_main_result: got %h want 0000000e", result); end
    stepPipe = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    stepPipe = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_abort(1'b0);
    test_abort(1'b1);
    test_back_to_back();
    test_unroll4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
